pipe_sched: RTL

PIPE_SCHED -- requirements
Module: pipe_sched

---
 rtl/pipe_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipe_sched.sv
// ---------------------------------------------------------------------------
// pipe_sched -- hazard / forwarding / multi-cycle-MUL scheduler for a
// five-stage in-order pipeline.
//
// Parameter
//   MUL_LAT      total cycles a MUL occupies EX (2..15)
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   id_valid     ID holds a valid instruction
//   id_ra/id_rb  ID source registers (operand A / operand B)
//   id_use_a/b   ID instruction really reads id_ra / id_rb
//   ex_valid     EX holds a valid instruction
//   ex_regwe     EX instruction writes ex_rd
//   ex_load      EX instruction is LW
//   ex_mul       EX instruction is MUL / MULI
//   ex_rd        EX destination register
//   wb_regwe     WB writes wb_rd this cycle
//   wb_rd        WB destination register
//   redirect     jump / taken branch resolved in EX
//   stall_pc     hold PC
//   stall_ifid   hold IF-ID register
//   stall_idex   hold ID-EX register
//   flush_ifid   replace IF-ID with NOP at next edge
//   bubble_idex  load NOP into ID-EX at next edge
//   fwd_a/fwd_b  operand source: 00 regfile, 01 EX result, 10 WB result
//   mul_start    one-cycle multiplier start pulse
//   busy         multiplier wait in progress
// All outputs are combinational from state, counter and inputs, and are all
// forced low while rst_n is low.
// ---------------------------------------------------------------------------
module pipe_sched #(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_ra,
    input  logic [2:0] id_rb,
    input  logic       id_use_a,
    input  logic       id_use_b,
    input  logic       ex_valid,
    input  logic       ex_regwe,
    input  logic       ex_load,
    input  logic       ex_mul,
    input  logic [2:0] ex_rd,
    input  logic       wb_regwe,
    input  logic [2:0] wb_rd,
    input  logic       redirect,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       flush_ifid,
    output logic       bubble_idex,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mul_start,
    output logic       busy
);

    typedef enum logic {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    // The entry cycle is one stall and the release cycle is none, so the
    // wait state only has to count the MUL_LAT-2 stall cycles in between.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Per-operand forwarding select; index 0 is operand A, 1 is operand B.
    logic [2:0] src_sel [2];
    logic       use_sel [2];
    logic [1:0] fwd_sel [2];
    logic [1:0] ex_load_hit;

    assign src_sel[0] = id_ra;
    assign src_sel[1] = id_rb;
    assign use_sel[0] = id_use_a;
    assign use_sel[1] = id_use_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic ex_hit;
            logic wb_hit;
            // A load's data is not ready at the end of EX, so it never
            // forwards from EX; the load-use stall covers that case.
            assign ex_hit = ex_valid && ex_regwe && !ex_load && (ex_rd == src_sel[gi]);
            assign wb_hit = wb_regwe && (wb_rd == src_sel[gi]);
            assign fwd_sel[gi] = ex_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);
            assign ex_load_hit[gi] = use_sel[gi] && (ex_rd == src_sel[gi]);
        end
    endgenerate

    logic load_use;
    assign load_use = id_valid && ex_valid && ex_load && ex_regwe && (|ex_load_hit);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        mul_start   = 1'b0;
        busy        = 1'b0;

        if (rst_n) begin
            fwd_a = fwd_sel[0];
            fwd_b = fwd_sel[1];
            case (state_reg)
                RUN: begin
                    // Priority: redirect, then MUL entry, then load-use.
                    if (redirect) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (ex_valid && ex_mul) begin
                        mul_start  = 1'b1;
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                        state_next = MULWAIT;
                        cnt_next   = CNT_LOAD;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end
                end
                MULWAIT: begin
                    // The MUL is still in EX here, so ex_mul / redirect /
                    // load-use are deliberately not looked at.
                    busy = 1'b1;
                    if (cnt_reg != 4'd0) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        stall_idex = 1'b1;
                        cnt_next   = cnt_reg - 4'd1;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule
